// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive deserializer
//
// Contents:
//   rx_state_e : receiver frame state (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN   : PAR_TYP value selecting even parity
//   PAR_ODD    : PAR_TYP value selecting odd parity
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - serial-line and parallel-word bundle of the UART receiver
//
// Signals:
//   RX_IN      serial line, idle high
//   PAR_EN     frame carries a parity bit
//   PAR_TYP    0 = even, 1 = odd parity
//   P_DATA     last good received word
//   Data_Valid one-cycle pulse, P_DATA updated
//   Par_Err    one-cycle pulse, parity mismatch
//   Stp_Err    one-cycle pulse, stop bit sampled low
//   busy       receiver is inside a frame
// Modports: master = pad/system side, slave = receiver side.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;
    logic                  busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, Par_Err, Stp_Err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, Par_Err, Stp_Err, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversampling counter and bit-value sampler
//
// Build option: RX_MAJORITY_VOTE_EN selects a 2-of-3 majority of three
// mid-bit samples; without it a single mid-bit sample is used.
//
// Ports:
//   CLK, RST     oversampling clock, asynchronous active-high reset
//   i_active     receiver is inside a frame (counter runs)
//   i_rx_sync    synchronized serial line
//   o_edge_cnt   position within the current bit, 0..OVERSAMPLE-1
//   o_bit        decided bit value, valid while o_decide is high
//   o_decide     decision strobe, edge_cnt == OVERSAMPLE/2+1
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8,
    parameter int CNT_W      = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_active,
    input  logic             i_rx_sync,
    output logic [CNT_W-1:0] o_edge_cnt,
    output logic             o_bit,
    output logic             o_decide
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] C_MID  = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);

    logic [CNT_W-1:0] r_edge_cnt;

    // Held at zero while idle, so every frame starts counting from 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_cnt <= '0;
        end else if (!i_active || (r_edge_cnt == C_LAST)) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + CNT_W'(1);
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] C_EARLY = CNT_W'(OVERSAMPLE / 2 - 1);

    logic r_smp_early;
    logic r_smp_mid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_smp_early <= 1'b1;
            r_smp_mid   <= 1'b1;
        end else begin
            if (r_edge_cnt == C_EARLY) r_smp_early <= i_rx_sync;
            if (r_edge_cnt == C_MID)   r_smp_mid   <= i_rx_sync;
        end
    end

    // Third vote is the live synchronized line during the decision cycle,
    // which keeps the decision point identical to the single-sample build.
    assign o_bit = (r_smp_early & r_smp_mid) |
                   (r_smp_early & i_rx_sync) |
                   (r_smp_mid   & i_rx_sync);
`else
    logic r_smp_mid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_smp_mid <= 1'b1;
        end else if (r_edge_cnt == C_MID) begin
            r_smp_mid <= i_rx_sync;
        end
    end

    assign o_bit = r_smp_mid;
`endif

    assign o_edge_cnt = r_edge_cnt;
    assign o_decide   = (r_edge_cnt == C_DEC);

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive deserializer: start qualify, data shift, parity/stop check
//
// Build option: RX_MAJORITY_VOTE_EN (see uart_rx_sampler) selects majority-vote
// bit sampling; latencies are the same in both builds.
//
// Ports:
//   CLK   oversampling clock (OVERSAMPLE cycles per bit)
//   RST   asynchronous active-high reset
//   bus   uart_rx_deserializer_if.slave: RX_IN, PAR_EN, PAR_TYP in;
//         P_DATA, Data_Valid, Par_Err, Stp_Err, busy out (all registered)
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_rx_deserializer_if.slave   bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic                  r_sync1;
    logic                  r_sync2;
    rx_state_e             r_state;
    logic                  r_busy;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic [CNT_W-1:0]      w_edge_cnt;
    logic                  w_bit;
    logic                  w_decide;
    logic                  w_bit_end;
    logic                  w_par_exp;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .i_active   (r_state != IDLE),
        .i_rx_sync  (r_sync2),
        .o_edge_cnt (w_edge_cnt),
        .o_bit      (w_bit),
        .o_decide   (w_decide)
    );

    assign w_bit_end = (w_edge_cnt == C_LAST);
    assign w_par_exp = (^r_shift) ^ (r_par_typ == PAR_ODD);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!r_sync2) begin
                        // Frame format is frozen for the whole frame here.
                        r_state   <= START;
                        r_busy    <= 1'b1;
                        r_par_en  <= bus.PAR_EN;
                        r_par_typ <= bus.PAR_TYP;
                        r_par_bad <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end

                START: begin
                    if (w_decide && w_bit) begin
                        // Line back high at mid-bit: a glitch, not a start bit.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (w_decide && (w_bit != w_par_exp)) begin
                        r_par_bad <= 1'b1;
                        r_par_err <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    // Leave at mid-stop-bit so a following start edge is not missed.
                    if (w_decide) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (!w_bit) begin
                            r_stp_err <= 1'b1;
                        end else if (!r_par_bad) begin
                            r_p_data     <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = r_p_data;
    assign bus.Data_Valid = r_data_valid;
    assign bus.Par_Err    = r_par_err;
    assign bus.Stp_Err    = r_stp_err;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed and randomized bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

    localparam int OS = 8;
    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST;
    int   edge_no = 0;
    int   nvec    = 0;
    int   nfail   = 0;
    logic [7:0] model_pdata = 8'h00;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_deserializer #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_no <= edge_no + 1;

    int         dv_e[$];
    logic [7:0] dv_d[$];
    logic       dv_busy[$];
    int         pe_e[$];
    int         se_e[$];
    int         br_e[$];
    logic       prev_busy = 1'b0;

    always @(negedge CLK) begin
        if (bus.Data_Valid) begin
            dv_e.push_back(edge_no);
            dv_d.push_back(bus.P_DATA);
            dv_busy.push_back(bus.busy);
        end
        if (bus.Par_Err) pe_e.push_back(edge_no);
        if (bus.Stp_Err) se_e.push_back(edge_no);
        if (bus.busy && !prev_busy) br_e.push_back(edge_no);
        prev_busy <= bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        dv_e.delete(); dv_d.delete(); dv_busy.delete();
        pe_e.delete(); se_e.delete(); br_e.delete();
    endtask

    // Line image of one frame, bit 0 first on the wire.
    task automatic build(input logic [7:0] d, input logic pe, input logic typ,
                         input logic flip, input logic stopb,
                         output logic [15:0] bits, output int n);
        bits = 16'hFFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        n = 1 + DW;
        if (pe) begin
            bits[n] = 1'(($countones(d) % 2) != 0) ^ typ ^ flip;
            n++;
        end
        bits[n] = stopb;
        n++;
    endtask

    // Caller is #1 after a posedge; the next posedge samples bit 0.
    // len100 is the bit length in hundredths of a clock cycle.
    task automatic send_bits(input logic [15:0] bits, input int n, input int len100, input int glitch);
        int t;
        int target;
        t = 0;
        for (int i = 0; i < n; i++) begin
            target = ((i + 1) * len100 + 99) / 100;
            while (t < target) begin
                bus.RX_IN = (t == glitch) ? ~bits[i] : bits[i];
                @(posedge CLK); #1;
                t++;
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic typ, input logic flip, input logic stopb,
                             input int glitch);
        logic [15:0] bits;
        int          n;
        int          t0;
        int          rel_end;
        int          rel_par;
        logic        exp_dv;
        logic        exp_pe;
        logic        exp_se;
        build(d, pe, typ, flip, stopb, bits, n);
        clear_q();
        bus.PAR_EN  = pe;
        bus.PAR_TYP = typ;
        t0 = edge_no + 1;
        send_bits(bits, n, 800, glitch);
        repeat (16) @(posedge CLK);
        #1;
        exp_pe  = pe & flip;
        exp_se  = ~stopb;
        exp_dv  = stopb & ~exp_pe;
        rel_end = 2 + OS * (1 + DW + int'(pe)) + OS / 2 + 2;
        rel_par = 2 + OS * (1 + DW) + OS / 2 + 2;
        if (exp_dv) model_pdata = d;
        check({tag, " dv_count"}, dv_e.size(), 32'(exp_dv));
        check({tag, " pe_count"}, pe_e.size(), 32'(exp_pe));
        check({tag, " se_count"}, se_e.size(), 32'(exp_se));
        check({tag, " busy_rise"}, (br_e.size() > 0) ? br_e[0] - t0 : -1, 2);
        if (exp_dv) begin
            check({tag, " dv_edge"}, dv_e[0] - t0, rel_end);
            check({tag, " dv_data"}, dv_d[0], d);
            check({tag, " busy_at_dv"}, dv_busy[0], 0);
        end
        if (exp_pe) check({tag, " pe_edge"}, (pe_e.size() > 0) ? pe_e[0] - t0 : -1, rel_par);
        if (exp_se) check({tag, " se_edge"}, (se_e.size() > 0) ? se_e[0] - t0 : -1, rel_end);
        check({tag, " p_data"}, bus.P_DATA, model_pdata);
        check({tag, " busy_end"}, bus.busy, 0);
    endtask

    initial begin
        logic [15:0] f1;
        logic [15:0] f2;
        int          n1;
        int          n2;
        int          t0;
        logic [7:0]  rd;
        logic        rpe;
        logic        rtyp;
        logic        rflip;
        logic        rstop;

        RST         = 1'b1;
        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst p_data", bus.P_DATA, 0);
        check("rst dv", bus.Data_Valid, 0);
        check("rst pe", bus.Par_Err, 0);
        check("rst se", bus.Stp_Err, 0);
        check("rst busy", bus.busy, 0);
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        run_frame("3c_even_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        run_frame("3c_even_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_frame("81_stop0", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Three-cycle low glitch on an idle line.
        clear_q();
        t0 = edge_no + 1;
        send_bits(16'h0000, 1, 300, -1);
        repeat (16) @(posedge CLK);
        #1;
        check("glitch busy_rises", br_e.size(), 1);
        check("glitch busy_rise", (br_e.size() > 0) ? br_e[0] - t0 : -1, 2);
        check("glitch dv_count", dv_e.size(), 0);
        check("glitch pe_count", pe_e.size(), 0);
        check("glitch se_count", se_e.size(), 0);
        check("glitch busy_end", bus.busy, 0);

`ifdef RX_MAJORITY_VOTE_EN
        run_frame("maj_glitch", 8'hB6, 1'b0, 1'b0, 1'b0, 1'b1, OS * 4 + 5);
`endif

        // Back-to-back frames at a 2% faster bit rate.
        clear_q();
        bus.PAR_EN = 1'b0;
        build(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, f1, n1);
        build(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, f2, n2);
        send_bits(f1, n1, 784, -1);
        send_bits(f2, n2, 784, -1);
        repeat (16) @(posedge CLK);
        #1;
        model_pdata = 8'hEE;
        check("b2b dv_count", dv_e.size(), 2);
        check("b2b data0", (dv_d.size() > 0) ? 32'(dv_d[0]) : 32'hDEAD_BEEF, 8'h11);
        check("b2b data1", (dv_d.size() > 1) ? 32'(dv_d[1]) : 32'hDEAD_BEEF, 8'hEE);
        check("b2b err_count", pe_e.size() + se_e.size(), 0);
        check("b2b p_data", bus.P_DATA, model_pdata);

        // Reset in the middle of the data bits.
        clear_q();
        build(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, f1, n1);
        send_bits(f1, 4, 800, -1);
        check("midrst busy_before", bus.busy, 1);
        #2;
        RST = 1'b1;
        #1;
        check("midrst p_data", bus.P_DATA, 0);
        check("midrst dv", bus.Data_Valid, 0);
        check("midrst pe", bus.Par_Err, 0);
        check("midrst se", bus.Stp_Err, 0);
        check("midrst busy", bus.busy, 0);
        model_pdata = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        check("midrst pulses", dv_e.size() + pe_e.size() + se_e.size(), 0);
        run_frame("5a_after_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);

        for (int k = 0; k < 12; k++) begin
            rd    = 8'($urandom);
            rpe   = 1'($urandom_range(0, 1));
            rtyp  = 1'($urandom_range(0, 1));
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rand%0d", k), rd, rpe, rtyp, rflip, rstop, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
